// File: rtl/sound_seq_multi.sv
// Multi-voice pattern sequencer: per-channel tone/noise dividers clocked by VGA line ticks,
// per-frame envelopes, and an x-positioned pulse-width output stage, OR-mixed into one bit.
module sound_seq_multi #(
    parameter int CHANNELS        = 2,
    parameter int STEPS           = 16,
    parameter int FRAMES_PER_STEP = 4,
    parameter int FREQ_W          = 8,
    parameter int ENV_W           = 5,
    parameter int ENV_DECAY       = 2,
    parameter int PWM_BASE        = 256,
    localparam int STEP_W         = (STEPS > 1) ? $clog2(STEPS) : 1,
    localparam int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          x,
    input  logic [9:0]          y,
    input  logic                enable,
    input  logic [CHANNELS-1:0] ch_noise,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [STEP_W-1:0]   wr_step,
    input  logic [FREQ_W-1:0]   wr_data,
    output logic                sound,
    output logic [CHANNELS-1:0] sound_ch,
    output logic [STEP_W-1:0]   step,
    output logic                pattern_wrap
);

    localparam int FC_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int WIN_W = ENV_W + 12;
    localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(FRAMES_PER_STEP - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
    localparam logic [ENV_W-1:0]  ENV_MAX   = '1;
    localparam logic [ENV_W-1:0]  ENV_DEC   = ENV_W'(ENV_DECAY);
    localparam logic [WIN_W-1:0]  BASE_L    = WIN_W'(PWM_BASE);
    localparam logic [14:0]       LFSR_SEED = 15'h7FFF;

    logic [9:0]          x_prev_reg;
    logic [FC_W-1:0]     frame_cnt_reg;
    logic [STEP_W-1:0]   step_reg;
    logic                first_reg;
    logic                wrap_reg;
    logic                sound_reg;
    logic [CHANNELS-1:0] sound_ch_reg;
    logic [CHANNELS-1:0] sound_ch_next;

    logic                line_tick;
    logic                frame_tick;
    logic                step_adv;
    logic                boundary;
    logic [STEP_W-1:0]   next_step;
    logic [WIN_W-1:0]    x_ext;

    // Ticks are gated by enable so every counter downstream freezes with it.
    assign line_tick  = enable && (x == 10'd0) && (x_prev_reg != 10'd0);
    assign frame_tick = line_tick && (y == 10'd0);
    assign step_adv   = frame_tick && !first_reg && (frame_cnt_reg == FC_LAST);
    assign boundary   = frame_tick && (first_reg || (frame_cnt_reg == FC_LAST));
    assign next_step  = step_adv ? (step_reg + STEP_W'(1)) : step_reg;
    assign x_ext      = WIN_W'(x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_prev_reg    <= '0;
            frame_cnt_reg <= '0;
            step_reg      <= '0;
            first_reg     <= 1'b1;
            wrap_reg      <= 1'b0;
        end else begin
            x_prev_reg <= x;
            wrap_reg   <= step_adv && (step_reg == STEP_LAST);
            if (frame_tick) begin
                first_reg     <= 1'b0;
                frame_cnt_reg <= (frame_cnt_reg == FC_LAST) ? '0 : frame_cnt_reg + FC_W'(1);
                step_reg      <= next_step;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [FREQ_W-1:0] pat_reg [STEPS];
            logic [FREQ_W-1:0] note_reg;
            logic [FREQ_W-1:0] div_reg;
            logic [ENV_W-1:0]  env_reg;
            logic              wave_reg;
            logic [14:0]       lfsr_reg;
            logic              wr_sel;
            logic [FREQ_W-1:0] rd_note;
            logic              voice;
            logic [WIN_W-1:0]  win_hi;

            assign wr_sel  = wr_en && (wr_ch == CH_W'(gi));
            // Write-first bypass so a write landing on the boundary read is not lost.
            assign rd_note = (wr_sel && (wr_step == next_step)) ? wr_data : pat_reg[next_step];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < STEPS; s++) begin
                        pat_reg[s] <= '0;
                    end
                end else if (wr_sel) begin
                    pat_reg[wr_step] <= wr_data;
                end
            end

            // Divider runs first on the old note; a coincident boundary then overrides it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    note_reg <= '0;
                    div_reg  <= '0;
                    env_reg  <= '0;
                    wave_reg <= 1'b0;
                    lfsr_reg <= LFSR_SEED;
                end else begin
                    if (line_tick && (note_reg != '0)) begin
                        if (div_reg >= note_reg) begin
                            div_reg <= '0;
                            if (ch_noise[gi]) begin
                                lfsr_reg <= {lfsr_reg[13:0], lfsr_reg[14] ^ lfsr_reg[13]};
                            end else begin
                                wave_reg <= ~wave_reg;
                            end
                        end else begin
                            div_reg <= div_reg + FREQ_W'(1);
                        end
                    end
                    if (boundary) begin
                        note_reg <= rd_note;
                        if (rd_note != '0) begin
                            env_reg  <= ENV_MAX;
                            div_reg  <= '0;
                            wave_reg <= 1'b1;
                        end else begin
                            env_reg  <= '0;
                            wave_reg <= 1'b0;
                        end
                    end else if (frame_tick) begin
                        env_reg <= (env_reg > ENV_DEC) ? (env_reg - ENV_DEC) : '0;
                    end
                end
            end

            // Pulse width tracks envelope: 8 pixels per envelope unit.
            assign voice  = ch_noise[gi] ? lfsr_reg[0] : wave_reg;
            assign win_hi = BASE_L + WIN_W'({env_reg, 3'b000});
            assign sound_ch_next[gi] = enable && voice && (x_ext >= BASE_L) && (x_ext < win_hi);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sound_ch_reg <= '0;
            sound_reg    <= 1'b0;
        end else begin
            sound_ch_reg <= sound_ch_next;
            sound_reg    <= |sound_ch_next;
        end
    end

    assign sound        = sound_reg;
    assign sound_ch     = sound_ch_reg;
    assign step         = step_reg;
    assign pattern_wrap = wrap_reg;

endmodule
